// File: rtl/train_pkg.sv
// Shared definitions for the train motion sequencer and the duration-lookup logic.
package train_pkg;

    // Present-state codes. The duration lookup decodes these same values.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_CHECK  = 4'b0010,
        ST_ACCEL  = 4'b0011,
        ST_CRUISE = 4'b0100,
        ST_BRAKE  = 4'b0101,
        ST_DOOR   = 4'b0110,
        ST_ESTOP  = 4'b1111
    } state_e;

    // Default phase durations (ms) and timing setup.
    localparam int CLK_PER_MS_DEF = 50000;
    localparam int T_ACCEL_DEF    = 2000;
    localparam int T_CRUISE_DEF   = 1000;
    localparam int T_BRAKE_DEF    = 2000;
    localparam int T_DOOR_DEF     = 3000;
    localparam int TW_DEF         = 19;

    // States whose dwell time is governed by the millisecond timer.
    function automatic logic is_timed(state_e s);
        return (s == ST_ACCEL) || (s == ST_CRUISE) || (s == ST_BRAKE) || (s == ST_DOOR);
    endfunction

endpackage

// File: rtl/train_sequencer_ms_timer.sv
// Millisecond prescaler plus loadable, saturating down-counter of remaining ms.
module ms_timer
    import train_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int TW         = TW_DEF
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic [TW-1:0] t_left_o,
    output logic          done_o
);

    // A one-cycle-per-ms setting still needs a 1-bit prescaler register.
    localparam int            PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] t_left_q, t_left_d;
    logic          tick;

    assign tick     = (presc_q == PRESC_MAX);
    assign t_left_o = t_left_q;
    assign done_o   = (t_left_q == '0);

    // Next prescaler / counter value; a load restarts the millisecond from zero.
    always_comb begin
        presc_d  = tick ? '0 : presc_q + PW'(1);
        t_left_d = t_left_q;
        if (load_i) begin
            presc_d  = '0;
            t_left_d = load_val_i;
        end else if (tick && (t_left_q != '0)) begin
            t_left_d = t_left_q - TW'(1);
        end
    end

    // Timer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q  <= '0;
            t_left_q <= '0;
        end else begin
            presc_q  <= presc_d;
            t_left_q <= t_left_d;
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Train motion sequencer: idle -> check -> accel -> cruise -> brake -> door -> idle,
// with emergency stop overriding every non-idle phase.
//
// state  | meaning
// IDLE   | parked, waiting for start (ignored while estop held)
// CHECK  | one-cycle pre-departure check
// ACCEL  | traction on for T_ACCEL ms
// CRUISE | traction on for at least T_CRUISE ms, leaves when station seen
// BRAKE  | brakes on for T_BRAKE ms
// DOOR   | doors open for T_DOOR ms
// ESTOP  | brakes on; leaves to IDLE on start with estop released
module train_sequencer
    import train_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int T_ACCEL    = T_ACCEL_DEF,
    parameter int T_CRUISE   = T_CRUISE_DEF,
    parameter int T_BRAKE    = T_BRAKE_DEF,
    parameter int T_DOOR     = T_DOOR_DEF,
    parameter int TW         = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          station_sensor,
    input  logic          estop,
    output logic [3:0]    present_state,
    output logic [TW-1:0] t_left,
    output logic          motor_en,
    output logic          brake_en,
    output logic          door_open,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;
    logic          motor_en_q, brake_en_q, door_open_q, busy_q;

    assign present_state = state_q;
    assign motor_en      = motor_en_q;
    assign brake_en      = brake_en_q;
    assign door_open     = door_open_q;
    assign busy          = busy_q;

    // Next-state logic; estop outranks every other condition outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !estop) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = estop ? ST_ESTOP : ST_ACCEL;
            end
            ST_ACCEL: begin
                if (estop)           state_d = ST_ESTOP;
                else if (timer_done) state_d = ST_CRUISE;
            end
            ST_CRUISE: begin
                if (estop)                             state_d = ST_ESTOP;
                else if (timer_done && station_sensor) state_d = ST_BRAKE;
            end
            ST_BRAKE: begin
                if (estop)           state_d = ST_ESTOP;
                else if (timer_done) state_d = ST_DOOR;
            end
            ST_DOOR: begin
                if (estop)           state_d = ST_ESTOP;
                else if (timer_done) state_d = ST_IDLE;
            end
            ST_ESTOP: begin
                if (!estop && start) state_d = ST_IDLE;
            end
            default: state_d = ST_ESTOP;
        endcase
    end

    // Load the phase duration on entry; untimed states hold the counter at zero.
    always_comb begin
        timer_load = (state_d != state_q) || !is_timed(state_d);
        case (state_d)
            ST_ACCEL:  timer_val = TW'(T_ACCEL);
            ST_CRUISE: timer_val = TW'(T_CRUISE);
            ST_BRAKE:  timer_val = TW'(T_BRAKE);
            ST_DOOR:   timer_val = TW'(T_DOOR);
            default:   timer_val = '0;
        endcase
    end

    ms_timer #(
        .CLK_PER_MS (CLK_PER_MS),
        .TW         (TW)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .t_left_o   (t_left),
        .done_o     (timer_done)
    );

    // State register and enables registered from the next state so they track present_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            motor_en_q  <= 1'b0;
            brake_en_q  <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            motor_en_q  <= (state_d == ST_ACCEL) || (state_d == ST_CRUISE);
            brake_en_q  <= (state_d == ST_BRAKE) || (state_d == ST_ESTOP);
            door_open_q <= (state_d == ST_DOOR);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer with short phase durations; a second
// instance with a zero-length door phase covers the one-cycle boundary.
module tb_train_sequencer;

    localparam int TW = 19;

    logic          clk;
    logic          reset, start, station_sensor, estop;
    logic [3:0]    ps;
    logic [TW-1:0] t_left;
    logic          motor_en, brake_en, door_open, busy;

    logic          reset_z, start_z;
    logic [3:0]    ps_z;
    logic [TW-1:0] t_left_z;
    logic          motor_en_z, brake_en_z, door_open_z, busy_z;

    int n_checks = 0;
    int n_errors = 0;

    train_sequencer #(
        .CLK_PER_MS(2), .T_ACCEL(3), .T_CRUISE(4), .T_BRAKE(5), .T_DOOR(2), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .station_sensor(station_sensor),
        .estop(estop), .present_state(ps), .t_left(t_left), .motor_en(motor_en),
        .brake_en(brake_en), .door_open(door_open), .busy(busy)
    );

    train_sequencer #(
        .CLK_PER_MS(2), .T_ACCEL(3), .T_CRUISE(4), .T_BRAKE(5), .T_DOOR(0), .TW(TW)
    ) dut_z (
        .clk(clk), .reset(reset_z), .start(start_z), .station_sensor(station_sensor),
        .estop(estop), .present_state(ps_z), .t_left(t_left_z), .motor_en(motor_en_z),
        .brake_en(brake_en_z), .door_open(door_open_z), .busy(busy_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles spent in state st, starting in its first cycle; bounded.
    task automatic measure(input logic [3:0] st, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((ps == st) && (n < 100));
    endtask

    // From IDLE, depart and stop in the first cycle of CRUISE.
    task automatic go_cruise();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (7) step();
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; station_sensor = 1'b1; estop = 1'b0;
        reset_z = 1'b1; start_z = 1'b0;
        step();
        step();
        check("rst_state", ps, 0);
        check("rst_tleft", t_left, 0);
        check("rst_enables", {motor_en, brake_en, door_open}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Normal trip
        start = 1'b1;
        step();
        start = 1'b0;
        check("trip_check_state", ps, 4'b0010);
        check("trip_check_busy", busy, 1);
        step();
        check("trip_accel_state", ps, 4'b0011);
        check("trip_accel_t3", t_left, 3);
        check("trip_accel_motor", motor_en, 1);
        repeat (2) step();
        check("trip_accel_t2", t_left, 2);
        repeat (2) step();
        check("trip_accel_t1", t_left, 1);
        repeat (2) step();
        check("trip_accel_t0", t_left, 0);
        check("trip_accel_still", ps, 4'b0011);
        step();
        check("trip_cruise_state", ps, 4'b0100);
        check("trip_cruise_t", t_left, 4);
        measure(4'b0100, n);
        check("trip_cruise_len", n, 9);
        check("trip_brake_state", ps, 4'b0101);
        check("trip_brake_en", brake_en, 1);
        check("trip_brake_motor", motor_en, 0);
        check("trip_brake_t", t_left, 5);
        measure(4'b0101, n);
        check("trip_brake_len", n, 11);
        check("trip_door_state", ps, 4'b0110);
        check("trip_door_open", door_open, 1);
        measure(4'b0110, n);
        check("trip_door_len", n, 5);
        check("trip_end_state", ps, 0);
        check("trip_end_busy", busy, 0);
        check("trip_end_door", door_open, 0);

        // Late station
        station_sensor = 1'b0;
        go_cruise();
        check("late_cruise_entry", ps, 4'b0100);
        repeat (20) step();
        check("late_hold_state", ps, 4'b0100);
        check("late_hold_t", t_left, 0);
        check("late_hold_motor", motor_en, 1);
        station_sensor = 1'b1;
        step();
        check("late_brake_state", ps, 4'b0101);
        measure(4'b0101, n);
        check("late_brake_len", n, 11);
        measure(4'b0110, n);
        check("late_door_len", n, 5);
        check("late_end_state", ps, 0);

        // Emergency in CRUISE
        go_cruise();
        repeat (2) step();
        check("estop_pre_state", ps, 4'b0100);
        estop = 1'b1;
        step();
        check("estop_state", ps, 4'b1111);
        check("estop_brake", brake_en, 1);
        check("estop_motor", motor_en, 0);
        check("estop_t", t_left, 0);
        check("estop_busy", busy, 1);
        estop = 1'b0;
        repeat (3) step();
        check("estop_hold", ps, 4'b1111);
        start = 1'b1;
        step();
        start = 1'b0;
        check("estop_exit_state", ps, 0);
        check("estop_exit_busy", busy, 0);
        check("estop_exit_brake", brake_en, 0);

        // estop on the same edge ACCEL is done
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (6) step();
        check("prio_accel_done_t", t_left, 0);
        check("prio_accel_state", ps, 4'b0011);
        estop = 1'b1;
        step();
        check("prio_state", ps, 4'b1111);
        estop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("prio_exit_state", ps, 0);

        // Reset mid-BRAKE
        go_cruise();
        repeat (9) step();
        check("rstb_brake_state", ps, 4'b0101);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstb_state", ps, 0);
        check("rstb_t", t_left, 0);
        check("rstb_enables", {motor_en, brake_en, door_open}, 0);
        check("rstb_busy", busy, 0);
        estop = 1'b1;
        start = 1'b1;
        repeat (2) step();
        check("idle_estop_state", ps, 0);
        check("idle_estop_busy", busy, 0);
        start = 1'b0;
        estop = 1'b0;

        // Zero-length door phase
        reset_z = 1'b0;
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        check("zero_check_state", ps_z, 4'b0010);
        step();
        check("zero_accel_state", ps_z, 4'b0011);
        repeat (7) step();
        check("zero_cruise_state", ps_z, 4'b0100);
        repeat (9) step();
        check("zero_brake_state", ps_z, 4'b0101);
        repeat (11) step();
        check("zero_door_state", ps_z, 4'b0110);
        check("zero_door_open", door_open_z, 1);
        check("zero_door_t", t_left_z, 0);
        step();
        check("zero_end_state", ps_z, 0);
        check("zero_end_door", door_open_z, 0);
        check("zero_end_busy", busy_z, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
